// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: timed PLL reset, lock qualification, retry tracking.
// Optional retry limit with FAULT state: define PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor #(
    parameter int NPLL          = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NPLL-1:0]                  pll_locked,
    input  logic                             relock_req,
    output logic                             pll_rst_n,
    output logic                             all_locked,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic                             fault
);

    localparam int C1   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX = (C1 > STABLE_CYCLES) ? C1 : STABLE_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY - 1);
`endif

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [RW-1:0]   retry_d;
    logic            armed;
    logic [NPLL-1:0] sync1;
    logic [NPLL-1:0] sync2;
    logic            lk;
    logic            rst_d;
    logic            al_d;

    // Two-flop synchronizer per raw lock bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pll_locked;
            sync2 <= sync1;
        end
    end

    assign lk = &sync2;

    // State, cycle counter and retry counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            armed     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            armed     <= 1'b1;
            retry_cnt <= retry_d;
        end
    end

    // Next state, counter and retry logic; release edge starts the reset pulse at count 0
    always_comb begin
        state_d = state;
        retry_d = retry_cnt;
        unique case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_STABLE;
                end else if (cnt == TO_LAST) begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
                    if (retry_cnt == RETRY_LIM) begin
                        retry_d = RETRY_MAX;
                        state_d = S_FAULT;
                    end else begin
                        retry_d = retry_cnt + 1'b1;
                        state_d = S_PLL_RST;
                    end
`else
                    if (retry_cnt != RETRY_MAX) retry_d = retry_cnt + 1'b1;
                    state_d = S_PLL_RST;
`endif
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt == ST_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!lk || relock_req) state_d = S_PLL_RST;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase

        if (state_d != state) begin
            cnt_d = '0;
        end else if (!armed || state == S_RUN || state == S_FAULT) begin
            cnt_d = cnt;
        end else begin
            cnt_d = cnt + 1'b1;
        end
    end

    // Output decode from the upcoming state so registered outputs move with the transition
    always_comb begin
        rst_d = !(state_d == S_PLL_RST || state_d == S_FAULT);
        al_d  = (state_d == S_RUN);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_n  <= 1'b0;
            all_locked <= 1'b0;
        end else begin
            pll_rst_n  <= rst_d;
            all_locked <= al_d;
        end
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    // Sticky fault flag, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault <= 1'b0;
        else        fault <= (state_d == S_FAULT);
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: vector table with scoreboard queue,
// plus hand sequences for asynchronous reset in mid-operation.
module tb_pll_lock_supervisor;

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam logic EN = 1'b1;
`else
    localparam logic EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pll_locked;
    logic       relock_req;
    logic       pll_rst_n;
    logic       all_locked;
    logic [1:0] retry_cnt;
    logic       fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] lk;
        logic       req;
        int         n;
        logic       rst;
        logic       al;
        logic [1:0] rc;
        logic       flt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [4:0] exp;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    pll_lock_supervisor #(
        .NPLL(2),
        .RST_CYCLES(4),
        .LOCK_TIMEOUT(32),
        .STABLE_CYCLES(8),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst_n(pll_rst_n),
        .all_locked(all_locked),
        .retry_cnt(retry_cnt),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {pll_rst_n, all_locked, retry_cnt, fault};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (pll_rst_n,all_locked,retry_cnt,fault)",
                     name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] lk, input logic req, input int n,
                       input logic rst, input logic al, input logic [1:0] rc,
                       input logic flt);
        tbl.push_back('{lk, req, n, rst, al, rc, flt});
    endtask

    initial begin
        exp_t e;
        rst_n      = 1'b1;
        pll_locked = 2'b00;
        relock_req = 1'b0;
        #2 rst_n = 1'b0;

        // power-up: 4-cycle reset pulse, locks raised 10 cycles after release
        add(2'b00, 0, 4, 0, 0, 2'd0, 0);
        add(2'b00, 0, 1, 1, 0, 2'd0, 0);
        add(2'b00, 0, 5, 1, 0, 2'd0, 0);
        add(2'b11, 0, 9, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 1, 2'd0, 0);
        // loss in RUN: effect two edges later
        add(2'b10, 0, 1, 1, 1, 2'd0, 0);
        add(2'b10, 0, 1, 1, 1, 2'd0, 0);
        add(2'b10, 0, 1, 0, 0, 2'd0, 0);
        add(2'b11, 0, 3, 0, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        // glitch 3 cycles into STABLE: qualification restarts
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 3, 1, 0, 2'd0, 0);
        add(2'b01, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 8, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 1, 2'd0, 0);
        // relock_req coinciding with lock drop: one 4-cycle reset
        add(2'b10, 0, 2, 1, 1, 2'd0, 0);
        add(2'b10, 1, 1, 0, 0, 2'd0, 0);
        add(2'b11, 0, 3, 0, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 0, 2'd0, 0);
        add(2'b11, 0, 7, 1, 0, 2'd0, 0);
        add(2'b11, 0, 1, 1, 1, 2'd0, 0);
        // relock_req alone in RUN, then timeouts with relock_req in WAIT_LOCK
        add(2'b11, 1, 1, 0, 0, 2'd0, 0);
        add(2'b01, 0, 3, 0, 0, 2'd0, 0);
        add(2'b01, 0, 1, 1, 0, 2'd0, 0);
        add(2'b01, 1, 1, 1, 0, 2'd0, 0);
        add(2'b01, 0, 30, 1, 0, 2'd0, 0);
        add(2'b01, 0, 1, 0, 0, 2'd1, 0);
        add(2'b01, 0, 3, 0, 0, 2'd1, 0);
        add(2'b01, 0, 1, 1, 0, 2'd1, 0);
        add(2'b01, 0, 31, 1, 0, 2'd1, 0);
        add(2'b01, 0, 1, 0, 0, 2'd2, EN);
        add(2'b01, 0, 4, !EN, 0, 2'd2, EN);
        add(2'b01, 0, 32, 0, 0, 2'd2, EN);

        repeat (3) @(negedge clk);
        check("reset_values", 5'b00000);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            pll_locked = tbl[i].lk;
            relock_req = tbl[i].req;
            sb.push_back('{i, {tbl[i].rst, tbl[i].al, tbl[i].rc, tbl[i].flt}});
            repeat (tbl[i].n) @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d", e.idx), e.exp);
        end
        relock_req = 1'b0;

        // async reset while in FAULT (or retrying): immediate return to reset values
        rst_n = 1'b0;
        #1 check("async_rst_fault", 5'b00000);
        #3 rst_n = 1'b1;
        pll_locked = 2'b11;

        // locks already high: RUN reached 14 edges after release
        repeat (13) @(posedge clk);
        @(negedge clk);
        check("relock_edge13", 5'b10000);
        @(posedge clk);
        @(negedge clk);
        check("relock_edge14", 5'b11000);

        // async reset while in RUN
        rst_n = 1'b0;
        #1 check("async_rst_run", 5'b00000);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_release", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Lock supervisor for the board PLLs, running on the buffered board reference clock. It watches the PLL `locked` indications and drives the PLL `rst_n` inputs. On power-up, on lock timeout, on loss of lock, or on a software request, it issues a timed PLL reset and re-arms. It reports qualified lock (`all_locked`), which gates fabric reset release, plus a retry count and a fault flag.

## Interface
Parameters:
- `NPLL`, 2: number of supervised PLLs (sys 80 MHz, eth 125 MHz).
- `RST_CYCLES`, 16: PLL reset pulse width in `clk` cycles, ≥2.
- `LOCK_TIMEOUT`, 65536: cycles allowed for all PLLs to lock after reset release.
- `STABLE_CYCLES`, 1024: cycles all locks must stay continuously high before qualification.
- `MAX_RETRY`, 7: failed attempts tolerated before FAULT (only used with macro).

Ports:
- `clk`  in  1: board reference clock, post-BUFG.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pll_locked`  in  NPLL: raw PLL lock outputs, asynchronous to `clk`.
- `relock_req`  in  1: single-cycle synchronous request to re-run PLL reset.
- `pll_rst_n`  out  1: active-low reset to all PLLs, registered.
- `all_locked`  out  1: qualified lock of all PLLs, registered.
- `retry_cnt`  out  $clog2(MAX_RETRY+1): consecutive failed lock attempts, saturating.
- `fault`  out  1: sticky retry-exhaustion flag.

## Operation
- `pll_locked` passes through a 2-FF synchronizer per bit; `lk` = AND of synchronized bits.
- One cycle counter `cnt`, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)). It clears on every state transition.
- States and transitions:
  - PLL_RST: `pll_rst_n`=0. When `cnt`==RST_CYCLES-1 → WAIT_LOCK.
  - WAIT_LOCK: `pll_rst_n`=1. If `lk` → STABLE. Else, when `cnt`==LOCK_TIMEOUT-1, increment `retry_cnt` (saturating) and → PLL_RST, or → FAULT (see Configuration).
  - STABLE: `pll_rst_n`=1; `cnt` increments while `lk`. If `lk` drops → WAIT_LOCK; `cnt` clears and the timeout restarts, with no retry counted. When `cnt`==STABLE_CYCLES-1 with `lk` high → RUN, and `retry_cnt` clears.
  - RUN: `all_locked`=1. If `lk` drops or `relock_req` is asserted → PLL_RST with `all_locked`=0.
  - FAULT: `pll_rst_n`=0, `fault`=1, `all_locked`=0. Exit only via `rst_n`.
- `relock_req` is ignored outside RUN.
- If `lk` drop and `relock_req` occur together in RUN, there is a single transition to PLL_RST.
- In WAIT_LOCK, if `lk` rises on the timeout cycle, `lk` wins: → STABLE, no retry.

## Timing
- Values while `rst_n`=0: state PLL_RST, `cnt`=0, `pll_rst_n`=0, `all_locked`=0, `retry_cnt`=0, `fault`=0, synchronizer flops 0.
- `rst_n` assertion mid-operation returns to these values immediately (asynchronously). Release is the first edge seen with `rst_n` high; PLL_RST then lasts exactly RST_CYCLES cycles.
- All outputs are registered and change on the edge of the state transition.
- Lock rise latency: `pll_locked` all high before edge k → synchronizer high after edge k+1 → STABLE at edge k+2 → `all_locked` high after edge k+2+STABLE_CYCLES.
- Loss latency: any `pll_locked` low before edge k → `all_locked`=0 and `pll_rst_n`=0 after edge k+2.
- `relock_req` sampled high at edge k in RUN → `all_locked`=0 and `pll_rst_n`=0 after edge k.

## Configuration
- `PLL_SUP_RETRY_LIMIT_EN` defined:
  - A timeout in WAIT_LOCK with `retry_cnt`==MAX_RETRY-1 sets `retry_cnt`=MAX_RETRY and enters FAULT.
  - FAULT holds PLLs in reset.
- `PLL_SUP_RETRY_LIMIT_EN` undefined:
  - FAULT is unreachable and `fault` is tied 0.
  - Retries continue indefinitely; `retry_cnt` saturates at MAX_RETRY.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2, NPLL=2.
- Power-up: release `rst_n`, raise both `pll_locked` 10 cycles after release → `pll_rst_n` low exactly 4 cycles; `all_locked` high exactly 10 cycles after the edge at which both locks are first sampled high; `retry_cnt`=0.
- Glitch in STABLE: drop `pll_locked[1]` for 1 cycle, 3 cycles into STABLE → returns to WAIT_LOCK; `pll_rst_n` stays 1; `retry_cnt`=0; qualification restarts from 0.
- Timeout: hold `pll_locked`=2'b01 → after 32 cycles in WAIT_LOCK, `retry_cnt`=1 and a 4-cycle `pll_rst_n` pulse. With macro, the second timeout → `fault`=1, `pll_rst_n`=0 held. Without macro, retries continue and `retry_cnt` sticks at 2.
- Loss in RUN: drop `pll_locked[0]` → `all_locked`=0 and `pll_rst_n`=0 two edges later; re-lock → `all_locked` returns and `retry_cnt` stays 0.
- `relock_req`: pulse in RUN together with a lock drop → exactly one PLL_RST of 4 cycles. Pulse in WAIT_LOCK → no effect.
- Async reset in FAULT or RUN: assert `rst_n` low for half a cycle → all outputs return to their reset values immediately; `fault` clears.
